// File: rtl/mbinit_cal_responder_pkg.sv
// Sideband message codes and widths shared by the MBINIT CAL initiator and responder.
package mbinit_cal_responder_pkg;

    localparam int SB_CODE_W = 4;

    localparam logic [SB_CODE_W-1:0] MBINIT_CAL_DONE_REQ  = 4'b0001;
    localparam logic [SB_CODE_W-1:0] MBINIT_CAL_DONE_RESP = 4'b0010;

endpackage

// File: rtl/ltsm_timeout_counter.sv
// Stage timeout counter: counts while enabled, clears on demand, flags the terminal value.
// Shared by the MBINIT responders; the owner freezes it by dropping en_i.
module ltsm_timeout_counter #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] terminal_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != terminal_i)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted only in the cycle the owner would leave on expiry, hence a single-cycle pulse.
    assign expire_o = en_i && !clr_i && (count_q == terminal_i);

endmodule

// File: rtl/mbinit_cal_responder.sv
// MBINIT.CAL responder: answers the partner's CAL Done request with a Done response
// and reports completion once the response has left the sideband transmitter.
module mbinit_cal_responder
    import mbinit_cal_responder_pkg::*;
#(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    i_MBINIT_PARAM_end,
    input  logic                    i_Busy_SideBand,
    input  logic                    i_falling_edge_busy,
    input  logic [SB_MSG_WIDTH-1:0] i_RX_SbMessage,
    input  logic                    i_msg_valid,
    output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
    output logic                    o_ValidOutDatat_Module,
    output logic                    o_MBINIT_CAL_Responder_end,
    output logic                    o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SB_MSG_WIDTH-1:0] REQ_CODE  = SB_MSG_WIDTH'(MBINIT_CAL_DONE_REQ);
    localparam logic [SB_MSG_WIDTH-1:0] RESP_CODE = SB_MSG_WIDTH'(MBINIT_CAL_DONE_RESP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_SEND_RESP,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic                    done_q, done_d;
    logic [SB_MSG_WIDTH-1:0] tx_q, tx_d;
    logic                    valid_q, valid_d;
    logic                    end_q, end_d;
    logic                    timeout_q, timeout_d;

    logic req;
    logic cnt_en;
    logic cnt_clr;
    logic cnt_expire;

    assign req = i_msg_valid && (i_RX_SbMessage == REQ_CODE);

    // The wait budget stops counting as soon as a request is known, even if busy delays the reply.
    assign cnt_en  = (state_q == S_WAIT_REQ) && !pending_q && !req;
    assign cnt_clr = (state_q != S_WAIT_REQ);

    ltsm_timeout_counter #(
        .WIDTH (CNT_W)
    ) u_timeout_counter (
        .clk        (CLK),
        .rst_n      (rst_n),
        .en_i       (cnt_en),
        .clr_i      (cnt_clr),
        .terminal_i (CNT_TERMINAL),
        .expire_o   (cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = done_q;

        if (!i_MBINIT_PARAM_end) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (req) begin
                        pending_d = 1'b1;
                    end
                    if ((pending_q || req) && !i_Busy_SideBand) begin
                        state_d = S_SEND_RESP;
                    end else if (cnt_expire) begin
                        state_d = S_TIMEOUT;
                    end
                end
                S_SEND_RESP: begin
                    if (i_falling_edge_busy && !i_Busy_SideBand) begin
                        state_d   = S_DONE;
                        pending_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
                S_DONE: begin
                    // Partner retransmits when it missed our response; answer again.
                    if (req) begin
                        pending_d = 1'b1;
                    end
                    if ((pending_q || req) && !i_Busy_SideBand) begin
                        state_d = S_SEND_RESP;
                    end
                end
                S_TIMEOUT: begin
                    state_d = S_TIMEOUT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        valid_d   = (state_d == S_SEND_RESP);
        tx_d      = valid_d ? RESP_CODE : '0;
        end_d     = (state_d == S_DONE) || ((state_d == S_SEND_RESP) && done_d);
        timeout_d = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            end_q     <= end_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_TX_SbMessage             = tx_q;
    assign o_ValidOutDatat_Module     = valid_q;
    assign o_MBINIT_CAL_Responder_end = end_q;
    assign o_timeout                  = timeout_q;

endmodule

// File: tb/tb_mbinit_cal_responder.sv
// Self-checking bench for mbinit_cal_responder: directed scenarios plus a randomized run,
// all compared against a flag-based behavioural model of the handshake.
module tb_mbinit_cal_responder;

    localparam int T = 16;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_MBINIT_PARAM_end = 1'b0;
    logic       i_Busy_SideBand = 1'b0;
    logic       i_falling_edge_busy = 1'b0;
    logic [3:0] i_RX_SbMessage = 4'h0;
    logic       i_msg_valid = 1'b0;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutDatat_Module;
    logic       o_MBINIT_CAL_Responder_end;
    logic       o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: flags describing where the handshake stands.
    bit m_active, m_pend, m_send, m_deliv, m_tout;
    int m_wait;

    mbinit_cal_responder #(
        .SB_MSG_WIDTH   (4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK                        (CLK),
        .rst_n                      (rst_n),
        .i_MBINIT_PARAM_end         (i_MBINIT_PARAM_end),
        .i_Busy_SideBand            (i_Busy_SideBand),
        .i_falling_edge_busy        (i_falling_edge_busy),
        .i_RX_SbMessage             (i_RX_SbMessage),
        .i_msg_valid                (i_msg_valid),
        .o_TX_SbMessage             (o_TX_SbMessage),
        .o_ValidOutDatat_Module     (o_ValidOutDatat_Module),
        .o_MBINIT_CAL_Responder_end (o_MBINIT_CAL_Responder_end),
        .o_timeout                  (o_timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] dut_vec();
        return {o_ValidOutDatat_Module, o_TX_SbMessage, o_MBINIT_CAL_Responder_end, o_timeout};
    endfunction

    function automatic logic [6:0] model_vec();
        return {m_send, (m_send ? 4'b0010 : 4'b0000), m_deliv, m_tout};
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic busy,
                              input logic fall, input logic vld, input logic [3:0] msg);
        bit req;
        req = vld && (msg == 4'b0001);
        if (!rst || !en) begin
            m_active = 0; m_pend = 0; m_send = 0; m_deliv = 0; m_tout = 0; m_wait = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_wait   = 0;
        end else if (m_tout) begin
            m_tout = 1;
        end else if (m_send) begin
            if (fall && !busy) begin
                m_send = 0; m_deliv = 1; m_pend = 0;
            end
        end else begin
            if (req) m_pend = 1;
            if (m_pend && !busy) begin
                m_send = 1;
            end else if (!m_deliv && !m_pend) begin
                if (m_wait == T - 1) m_tout = 1;
                else m_wait++;
            end
        end
    endtask

    task automatic step(input logic en, input logic busy, input logic fall,
                        input logic vld, input logic [3:0] msg);
        i_MBINIT_PARAM_end  = en;
        i_Busy_SideBand     = busy;
        i_falling_edge_busy = fall;
        i_msg_valid         = vld;
        i_RX_SbMessage      = msg;
        @(posedge CLK);
        model_edge(rst_n, en, busy, fall, vld, msg);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);
            n_tests++;
            if (dut_vec() !== 7'b0) begin
                n_fail++;
                $display("FAIL reset c=%0d got=%b exp=%b", c, dut_vec(), 7'b0);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, (c >= 4 && c <= 6), (c == 7), (c == 3), 4'b0001);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL basic c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
            if (c == 3) begin
                n_tests++;
                if ({o_ValidOutDatat_Module, o_TX_SbMessage} !== 5'b1_0010) begin
                    n_fail++;
                    $display("FAIL basic_first_tx got=%b exp=%b",
                             {o_ValidOutDatat_Module, o_TX_SbMessage}, 5'b1_0010);
                end
            end
            if (c == 7) begin
                n_tests++;
                if ({o_ValidOutDatat_Module, o_MBINIT_CAL_Responder_end} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL basic_complete got=%b exp=01",
                             {o_ValidOutDatat_Module, o_MBINIT_CAL_Responder_end});
                end
            end
        end
    endtask

    task automatic test_busy_holdoff();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            step(1'b1, (c < 9), (c == 9), (c == 2), 4'b0001);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL holdoff c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
            n_tests++;
            if (o_ValidOutDatat_Module !== (c >= 9)) begin
                n_fail++;
                $display("FAIL holdoff_valid c=%0d got=%b exp=%b", c, o_ValidOutDatat_Module, (c >= 9));
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 25; c++) begin
            step(1'b1, 1'b0, 1'b0, (c == 20), 4'b0001);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL timeout c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
            n_tests++;
            if ({o_timeout, o_ValidOutDatat_Module} !== {(c >= T), 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_edge c=%0d got=%b exp=%b",
                         c, {o_timeout, o_ValidOutDatat_Module}, {(c >= T), 1'b0});
            end
        end
    endtask

    task automatic test_retransmit();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, (c == 3 || c == 7 || c == 8), (c == 4 || c == 9),
                 (c == 2 || c == 6), 4'b0001);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL retransmit c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
            if (c >= 4) begin
                n_tests++;
                if (o_MBINIT_CAL_Responder_end !== 1'b1) begin
                    n_fail++;
                    $display("FAIL retransmit_end_sticky c=%0d got=%b exp=1", c, o_MBINIT_CAL_Responder_end);
                end
            end
            if (c >= 6 && c <= 8) begin
                n_tests++;
                if ({o_ValidOutDatat_Module, o_TX_SbMessage} !== 5'b1_0010) begin
                    n_fail++;
                    $display("FAIL retransmit_resend c=%0d got=%b exp=10010",
                             c, {o_ValidOutDatat_Module, o_TX_SbMessage});
                end
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        for (int c = 0; c < 22; c++) begin
            step((c != 3), (c == 2), 1'b0, (c == 1), 4'b0001);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL abort c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
            if (c == 3) begin
                n_tests++;
                if (dut_vec() !== 7'b0) begin
                    n_fail++;
                    $display("FAIL abort_clear got=%b exp=%b", dut_vec(), 7'b0);
                end
            end
            if (c >= 4) begin
                n_tests++;
                if (o_timeout !== (c >= 4 + T)) begin
                    n_fail++;
                    $display("FAIL abort_restart c=%0d got=%b exp=%b", c, o_timeout, (c >= 4 + T));
                end
            end
        end
    endtask

    task automatic test_filter_and_reset();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            logic       vld;
            logic [3:0] msg;
            vld = (c == 4 || c == 6 || c == 9);
            msg = (c == 4) ? 4'b0010 : (c == 6) ? 4'b1111 : 4'b0001;
            rst_n = (c != 11);
            step(1'b1, (c == 10), 1'b0, vld, msg);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL filter c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
            n_tests++;
            if (o_ValidOutDatat_Module !== (c == 9 || c == 10)) begin
                n_fail++;
                $display("FAIL filter_valid c=%0d got=%b exp=%b", c, o_ValidOutDatat_Module, (c == 9 || c == 10));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic       en = 1'b1;
        logic       busy = 1'b0;
        logic       prev_busy;
        logic       fall;
        logic       vld;
        logic [3:0] msg;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (en) en = ($urandom_range(0, 79) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            prev_busy = busy;
            if ($urandom_range(0, 3) == 0) busy = !busy;
            fall = prev_busy && !busy;
            vld  = ($urandom_range(0, 5) == 0);
            msg  = 4'($urandom_range(0, 3));
            step(en, busy, fall, vld, msg);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec(), model_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_busy_holdoff();
        test_timeout();
        test_retransmit();
        test_abort();
        test_filter_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
